// File: rtl/sys_matmul_stream.sv
// sys_matmul_stream: streaming N x N signed matrix multiply, C = A*B.
// A and B arrive as one serial beat stream, are buffered, and are fed with
// row/column skew into an output-stationary systolic array. C is then
// returned row-major with out_last on the final element.
// Optional macro SYS_ACCUM_EN adds the accum port. With accum=1 on the final
// input beat, the array keeps the previous job's sums (C += A*B).
//
// Handshakes: a beat transfers on a rising CLK edge where valid and ready
// are both high. The producer holds valid and data until that edge. Ready
// may be low while valid is high. in_vld is ignored outside LOAD, and
// out_rdy is ignored outside DRAIN.
module sys_matmul_stream #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(N)
) (
  input  logic                    CLK,
  input  logic                    rstb,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic signed [DW-1:0]    a_in,
  input  logic signed [DW-1:0]    b_in,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [ACC_W-1:0] c_out,
  output logic                    out_last,
  output logic                    busy,
  output logic [1:0]              dbg_state
`ifdef SYS_ACCUM_EN
  ,
  input  logic                    accum
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(3*N);

  typedef enum logic [1:0] {LOAD = 2'd0, COMPUTE = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_nxt;

  logic [IW-1:0] ld_i, ld_k;
  logic [IW-1:0] out_r, out_c, nxt_r, nxt_c;
  logic [CW-1:0] cyc;
  logic          in_hs, out_hs, last_beat, keep, clr;

  logic signed [DW-1:0]    a_buf  [N][N];
  logic signed [DW-1:0]    b_buf  [N][N];
  logic signed [DW-1:0]    a_feed [N];
  logic signed [DW-1:0]    b_feed [N];
  logic signed [DW-1:0]    a_pipe [N][N];
  logic signed [DW-1:0]    b_pipe [N][N];
  logic signed [2*DW-1:0]  prod   [N][N];
  logic signed [ACC_W-1:0] acc    [N][N];

  assign in_rdy    = rstb && (state == LOAD);
  assign busy      = (state == COMPUTE) || (state == DRAIN);
  assign dbg_state = state;
  assign in_hs     = in_vld && (state == LOAD);
  assign out_hs    = out_vld && out_rdy && (state == DRAIN);
  assign last_beat = (ld_i == IW'(N-1)) && (ld_k == IW'(N-1));

`ifdef SYS_ACCUM_EN
  assign keep = accum;
`else
  assign keep = 1'b0;
`endif
  assign clr = in_hs && last_beat && !keep;

  // State register.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic: LOAD -> COMPUTE -> DRAIN -> LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && last_beat) state_nxt = COMPUTE;
      COMPUTE: if (cyc == CW'(3*N-2)) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Beat t = k*N + i carries A[i][k] and B[k][i]. Store them transposed-free.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      ld_i <= '0;
      ld_k <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
    end else if (in_hs) begin
      a_buf[ld_i][ld_k] <= a_in;
      b_buf[ld_k][ld_i] <= b_in;
      if (ld_i == IW'(N-1)) begin
        ld_i <= '0;
        ld_k <= last_beat ? '0 : ld_k + 1'b1;
      end else begin
        ld_i <= ld_i + 1'b1;
      end
    end
  end

  // Compute-cycle counter. It restarts at 0 on every entry to COMPUTE.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb)                 cyc <= '0;
    else if (state == COMPUTE) cyc <= cyc + 1'b1;
    else                       cyc <= '0;
  end

  // Skewed feed: row i sees A[i][c-i], column j sees B[c-j][j], else zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
    end
    if (state == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(cyc) >= i) && (int'(cyc) < i + N)) begin
          a_feed[i] = a_buf[i][IW'(int'(cyc) - i)];
          b_feed[i] = b_buf[IW'(int'(cyc) - i)][i];
        end
      end
    end
  end

  // Full-precision per-PE product.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = a_pipe[i][j] * b_pipe[i][j];
  end

  // Systolic array: A flows right, B flows down, and each PE accumulates in place.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else begin
      if (state == COMPUTE) begin
        for (int i = 0; i < N; i++) begin
          a_pipe[i][0] <= a_feed[i];
          b_pipe[0][i] <= b_feed[i];
          for (int j = 1; j < N; j++) begin
            a_pipe[i][j] <= a_pipe[i][j-1];
            b_pipe[j][i] <= b_pipe[j-1][i];
          end
        end
      end else begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            a_pipe[i][j] <= '0;
            b_pipe[i][j] <= '0;
          end
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (clr)
            acc[i][j] <= '0;
          else if (state == COMPUTE)
            acc[i][j] <= acc[i][j] +
                         {{(ACC_W-2*DW){prod[i][j][2*DW-1]}}, prod[i][j]};
        end
    end
  end

  // Row-major successor of the current output index.
  always_comb begin
    nxt_r = out_r;
    nxt_c = out_c + 1'b1;
    if (out_c == IW'(N-1)) begin
      nxt_c = '0;
      nxt_r = out_r + 1'b1;
    end
  end

  // Registered result stream. PE(0,0) is final long before the DRAIN entry edge.
  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      c_out    <= '0;
      out_r    <= '0;
      out_c    <= '0;
    end else if ((state == COMPUTE) && (state_nxt == DRAIN)) begin
      out_vld  <= 1'b1;
      out_last <= 1'b0;
      c_out    <= acc[0][0];
      out_r    <= '0;
      out_c    <= '0;
    end else if (out_hs) begin
      if (out_last) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end else begin
        out_r    <= nxt_r;
        out_c    <= nxt_c;
        c_out    <= acc[nxt_r][nxt_c];
        out_last <= (nxt_r == IW'(N-1)) && (nxt_c == IW'(N-1));
      end
    end
  end

endmodule

// File: doc/sys_matmul_stream.md
# sys_matmul_stream

Parametrised streaming matrix-multiply engine: accepts two N×N signed matrices as a single serial beat stream, computes C = A·B on an internal N×N output-stationary systolic array, and returns C serially. Successor to the fixed 3×3 byte-serial engine, generalised in dimension, operand width and accumulator width. Adds `out_last` framing, full valid/ready backpressure on both sides, and optional tile accumulation. Sits between the SPI/host front-end and downstream consumers.

## Interface
- `N`, 4, matrix dimension (2..16)
- `DW`, 8, operand width, signed two's complement
- `ACC_W`, 2*DW+$clog2(N), accumulator/result width, signed
- `CLK`  in  1  clock, rising edge
- `rstb`  in  1  reset; asynchronous assert, active-low (fixed)
- `in_vld`  in  1  input beat valid
- `in_rdy`  out  1  engine accepts a beat
- `a_in`  in  DW  A operand of current beat
- `b_in`  in  DW  B operand of current beat
- `out_vld`  out  1  `c_out` valid
- `out_rdy`  in  1  consumer accepts `c_out`
- `c_out`  out  ACC_W  result element
- `out_last`  out  1  high on final result beat (C[N-1][N-1])
- `busy`  out  1  high in COMPUTE or DRAIN
- `accum`  in  1  only with `SYS_ACCUM_EN`; see Configuration

## Operation
- Input order: beat t = k*N + i carries `a_in`=A[i][k], `b_in`=B[k][i], t = 0..N²-1 (A column-major, B row-major).
- FSM states LOAD → COMPUTE → DRAIN → LOAD.
- LOAD: `in_rdy`=1; handshake (`in_vld`&`in_rdy`) writes beat into A/B buffers, beat counter +1. Handshake on beat N²-1 → COMPUTE; counter wraps to 0.
- COMPUTE: `in_rdy`=0; buffers fed with row/column skew into array; PE(i,j) accumulates A[i][k]*B[k][j], full-precision product sign-extended to ACC_W; sum wraps modulo 2^ACC_W. Fixed 3N-1 cycles, then DRAIN.
- DRAIN: C emitted row-major, C[0][0] … C[N-1][N-1]; `out_vld`=1; element index advances only on `out_vld`&`out_rdy`. Handshake with `out_last`=1 → LOAD.
- Accumulators clear at entry to COMPUTE (unless accumulate mode, below).
- `in_vld` and operands ignored outside LOAD; `out_rdy` ignored outside DRAIN.

## Timing
- Reset values: `in_rdy`=1 (after release; 0 while `rstb`=0), `out_vld`=0, `c_out`=0, `out_last`=0, `busy`=0; FSM=LOAD, counters 0, accumulators 0.
- `rstb` low in any state aborts job immediately; partial inputs and results discarded.
- Last input handshake at edge E: `busy` high from E; `out_vld` first high in cycle after edge E+3N-1; latency independent of `out_rdy`.
- `out_rdy` low: `c_out`, `out_vld`, `out_last` held stable.
- Outputs registered; no combinational path in→out.
- Edge accepting the final result: `in_rdy` high, `busy` low next cycle; next job's first beat accepted on the following edge at the earliest.
- Input gaps (`in_vld`=0) pause beat counter; no effect on results.

## Configuration
- `SYS_ACCUM_EN` defined: `accum` port present, sampled on the final input handshake; `accum`=1 keeps previous job's accumulators (C += A·B, for K-tiling), `accum`=0 clears. Reset always clears.
- Undefined: no `accum` port; accumulators always clear at COMPUTE entry.

## Test plan
- N=3, A=B=I₃ → `c_out` sequence 1,0,0,0,1,0,0,0,1; `out_last` only on 9th beat; first `out_vld` at E+3N.
- N=3, A={{1,1,0},{0,1,0},{0,1,1}}, B={{1,0,0},{0,2,0},{2,0,1}} → 1,2,0,0,2,0,2,2,1.
- N=3, all A=B=-128 → every element 49152; A all -128, B all 127 → every element -48768.
- Random `in_vld` gaps and `out_rdy` stalls, back-to-back jobs → results match model; `c_out` stable during stall.
- `rstb` low mid-COMPUTE, then identity job → clean identity result, no residue; all outputs at reset values while low.
- With `SYS_ACCUM_EN`: identity job (accum=0) then identity job (accum=1) → diagonal 2, off-diagonal 0.
